// File: rtl/pc8001m_ps2_pkg.sv
// Shared types and helpers for the PS/2 key serializer.
// Used by ps2_key_serializer (optional typematic via PS2_TYPEMATIC_EN) and its byte FIFO.
package pc8001m_ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } ser_state_t;

  localparam logic [7:0]  PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0]  PS2_BREAK_PREFIX = 8'hF0;
  localparam int unsigned PS2_FRAME_CELLS  = 11;

  // Parity bit that makes the 9-bit {parity, data} group contain an odd number of ones
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data and occupancy count.
// Simultaneous push and pop are allowed; push when full and pop when empty are ignored.
module ps2_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_push,
  input  logic [7:0]                      i_din,
  input  logic                            i_pop,
  output logic [7:0]                      o_dout_c,
  output logic [$clog2(FIFO_DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = i_push && (r_count != CW'(FIFO_DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign o_dout_c  = r_mem[r_rd];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

endmodule

// File: rtl/ps2_key_serializer.sv
// Turns hps_io ps2_key toggle events into PS/2 device-to-host frames via a byte FIFO.
// Optional key auto-repeat is compiled in when PS2_TYPEMATIC_EN is defined.
module ps2_key_serializer
  import pc8001m_ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 28636360,
  parameter int unsigned PS2_HZ     = 12500,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_BITS   = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned HALF    = CLK_HZ / (2 * PS2_HZ);
  localparam int unsigned CELL    = 2 * HALF;
  localparam int unsigned GAP_LEN = (GAP_BITS * CELL > 0) ? GAP_BITS * CELL : 1;
  localparam int unsigned TMAX    = (CELL > GAP_LEN) ? CELL : GAP_LEN;
  localparam int unsigned TW      = $clog2(TMAX + 1);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

  // ---------------- event admission ----------------
  logic          r_primed;
  logic          r_key_prev;
  logic [7:0]    r_pend0;
  logic [7:0]    r_pend1;
  logic [1:0]    r_pend_cnt;
  logic          r_overflow;
  logic          w_toggle;
  logic          w_rep_req;
  logic          w_rep_ext;
  logic [7:0]    w_rep_code;
  logic          w_evt;
  logic          w_press;
  logic          w_ext;
  logic [7:0]    w_code;
  logic [1:0]    w_n;
  logic [7:0]    w_b0;
  logic [7:0]    w_b1;
  logic [7:0]    w_b2;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic          w_accept;
  logic          w_drop;
  logic          w_push;
  logic [7:0]    w_din;
  logic          w_pop;
  logic [7:0]    w_dout;

  assign w_toggle = r_primed && (ps2_key[10] != r_key_prev);
  assign w_evt    = (r_pend_cnt == 2'd0) && (w_toggle || w_rep_req);
  assign w_press  = w_toggle ? ps2_key[9]   : 1'b1;
  assign w_ext    = w_toggle ? ps2_key[8]   : w_rep_ext;
  assign w_code   = w_toggle ? ps2_key[7:0] : w_rep_code;

  // Byte sequence: optional E0, optional F0, then the scan code
  always_comb begin
    w_n  = 2'd1;
    w_b0 = w_code;
    w_b1 = '0;
    w_b2 = '0;
    unique case ({w_ext, ~w_press})
      2'b10: begin w_n = 2'd2; w_b0 = PS2_EXT_PREFIX;   w_b1 = w_code; end
      2'b01: begin w_n = 2'd2; w_b0 = PS2_BREAK_PREFIX; w_b1 = w_code; end
      2'b11: begin w_n = 2'd3; w_b0 = PS2_EXT_PREFIX;   w_b1 = PS2_BREAK_PREFIX; w_b2 = w_code; end
      default: ;
    endcase
  end

  assign w_free   = CW'(FIFO_DEPTH) - w_count;
  assign w_accept = w_evt && (w_free >= CW'(w_n));
  assign w_drop   = w_evt && !w_accept;
  assign w_push   = w_accept || (r_pend_cnt != 2'd0);
  assign w_din    = w_accept ? w_b0 : r_pend0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_primed   <= 1'b0;
      r_key_prev <= 1'b0;
      r_pend0    <= '0;
      r_pend1    <= '0;
      r_pend_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (!r_primed) begin
        r_primed   <= 1'b1;
        r_key_prev <= ps2_key[10];
      end else if (w_evt && w_toggle) begin
        r_key_prev <= ps2_key[10];
      end
      if (w_accept) begin
        r_pend0    <= w_b1;
        r_pend1    <= w_b2;
        r_pend_cnt <= w_n - 2'd1;
      end else if (r_pend_cnt != 2'd0) begin
        r_pend0    <= r_pend1;
        r_pend_cnt <= r_pend_cnt - 2'd1;
      end
    end
  end

`ifdef PS2_TYPEMATIC_EN
  localparam longint unsigned TM_DELAY = 64'(CLK_HZ) / 2;
  localparam longint unsigned TM_RATE  = (64'(CLK_HZ) * 92) / 1000;
  localparam int unsigned     TMW      = $clog2(TM_DELAY + 1);

  logic           r_tm_valid;
  logic           r_tm_first;
  logic           r_tm_req;
  logic           r_tm_ext;
  logic [7:0]     r_tm_code;
  logic [TMW-1:0] r_tm_cnt;
  logic [TMW-1:0] w_tm_target;

  assign w_rep_req   = r_tm_req;
  assign w_rep_ext   = r_tm_ext;
  assign w_rep_code  = r_tm_code;
  assign w_tm_target = r_tm_first ? TMW'(TM_DELAY - 1) : TMW'(TM_RATE - 1);

  // Tracks the last pressed key and raises a repeat request at delay, then at rate
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tm_valid <= 1'b0;
      r_tm_first <= 1'b1;
      r_tm_req   <= 1'b0;
      r_tm_ext   <= 1'b0;
      r_tm_code  <= '0;
      r_tm_cnt   <= '0;
    end else if (w_evt && w_toggle) begin
      r_tm_req   <= 1'b0;
      r_tm_cnt   <= '0;
      r_tm_first <= 1'b1;
      if (ps2_key[9]) begin
        r_tm_valid <= 1'b1;
        r_tm_ext   <= ps2_key[8];
        r_tm_code  <= ps2_key[7:0];
      end else if ({ps2_key[8], ps2_key[7:0]} == {r_tm_ext, r_tm_code}) begin
        r_tm_valid <= 1'b0;
      end
    end else begin
      if (w_evt) r_tm_req <= 1'b0;
      if (r_tm_valid) begin
        if (r_tm_cnt == w_tm_target) begin
          r_tm_req   <= 1'b1;
          r_tm_cnt   <= '0;
          r_tm_first <= 1'b0;
        end else begin
          r_tm_cnt <= r_tm_cnt + TMW'(1);
        end
      end
    end
  end
`else
  assign w_rep_req  = 1'b0;
  assign w_rep_ext  = 1'b0;
  assign w_rep_code = '0;
`endif

  ps2_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .i_push   (w_push),
    .i_din    (w_din),
    .i_pop    (w_pop),
    .o_dout_c (w_dout),
    .o_count  (w_count)
  );

  // ---------------- serializer ----------------
  ser_state_t    r_state;
  ser_state_t    w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_par;
  logic          w_par_nxt;
  logic          r_clk;
  logic          w_clk_nxt;
  logic          r_data;
  logic          w_data_nxt;
  logic          r_busy;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Each bit cell: clock high for HALF cycles, then low for HALF; data changes at cell start
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_clk_nxt   = r_clk;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clk_nxt  = 1'b1;
        w_data_nxt = 1'b1;
        if (w_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_dout;
          w_par_nxt   = odd_parity(w_dout);
          w_bit_nxt   = '0;
          w_tick_nxt  = '0;
          w_data_nxt  = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        w_tick_nxt = r_tick + TW'(1);
        if (r_tick == TW'(HALF - 1)) w_clk_nxt = 1'b0;
        if (r_tick == TW'(CELL - 1)) begin
          w_tick_nxt = '0;
          w_clk_nxt  = 1'b1;
          unique case (r_state)
            S_START: begin
              w_state_nxt = S_DATA;
              w_data_nxt  = r_shift[0];
            end
            S_DATA: begin
              if (r_bit == 3'd7) begin
                w_state_nxt = S_PARITY;
                w_data_nxt  = r_par;
              end else begin
                w_bit_nxt   = r_bit + 3'd1;
                w_shift_nxt = r_shift >> 1;
                w_data_nxt  = r_shift[1];
              end
            end
            S_PARITY: begin
              w_state_nxt = S_STOP;
              w_data_nxt  = 1'b1;
            end
            default: begin
              w_state_nxt = S_GAP;
              w_data_nxt  = 1'b1;
            end
          endcase
        end
      end
      S_GAP: begin
        w_clk_nxt  = 1'b1;
        w_data_nxt = 1'b1;
        w_tick_nxt = r_tick + TW'(1);
        if (r_tick == TW'(GAP_LEN - 1)) begin
          w_tick_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_clk   <= w_clk_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= (w_count != '0) || (r_state != S_IDLE);
    end
  end

  assign ps2_clk  = r_clk;
  assign ps2_data = r_data;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule

// File: doc/ps2_key_serializer.md
Name: ps2_key_serializer

Overview:
- Converts the 11-bit hps_io `ps2_key` event word into a genuine PS/2 device-to-host serial stream on `ps2_clk`/`ps2_data`.
- Drives the pc8001m keyboard input, which currently has no connection.
- Sits between hps_io and pc8001m in the `clk_sys` domain (28.63636 MHz).
- Buffers scan-code bytes in a small FIFO so that bursts of key events are never truncated mid-sequence.

Parameters:
- CLK_HZ, 28636360, `clk_sys` frequency in Hz.
- PS2_HZ, 12500, PS/2 clock rate in Hz. Half-period HALF = CLK_HZ/(2*PS2_HZ), integer floor; 1145 at defaults.
- FIFO_DEPTH, 16, byte FIFO depth; must be a power of two and at least 4.
- GAP_BITS, 2, minimum idle bit-times (both lines high) between frames.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  [10] toggles per event, [9] 1=press, [8] extended (E0 prefix), [7:0] scan code
- ps2_clk  out  1  PS/2 clock; idle 1
- ps2_data  out  1  PS/2 data; idle 1
- busy  out  1  FIFO non-empty or frame in progress
- overflow  out  1  one-cycle pulse when an event is dropped

Behaviour:
- Reset (async, reset_n=0):
  - ps2_clk=1, ps2_data=1, busy=0, overflow=0.
  - FIFO emptied; serializer goes to IDLE; `primed` flag cleared.
  - The first clock edge after reset release copies `ps2_key[10]` into `key_prev` and sets `primed`. No event is generated on that edge.
- Event detection:
  - When `primed` and `ps2_key[10]` differs from `key_prev`, an event is pending.
  - The bytes to enqueue are, in order: E0 (if [8]), F0 (if ![9]), then [7:0]. N = 1..3.
- Admission is atomic:
  - The event is accepted only if FIFO free slots ≥ N. Bytes are then pushed on N consecutive cycles and `key_prev` is updated on the first push.
  - If free slots < N, the event is dropped whole: overflow pulses 1 cycle and `key_prev` is updated.
  - A toggle that arrives during an ongoing push stays pending, because `key_prev` still differs. It is evaluated after the push completes.
- FIFO: synchronous; a push and a pop in the same cycle are both legal. Count width is $clog2(FIFO_DEPTH)+1.
- Serializer FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE: if the FIFO is non-empty, pop a byte into the shift register, clear the bit counter, and go to START.
  - Each bit cell is 2×HALF cycles long:
    - ps2_data is updated at the cell start while ps2_clk=1.
    - ps2_clk=1 for the first HALF cycles, then 0 for HALF cycles (host samples on the falling edge).
  - START drives 0. DATA drives 8 bits LSB first, counter 0..7. PARITY drives odd parity (~^byte). STOP drives 1.
  - GAP holds both lines 1 for GAP_BITS×2×HALF cycles, then returns to IDLE.
  - Frame length is 11 cells; at defaults one frame = 11×2290 = 25190 cycles.
- busy = FIFO non-empty OR state≠IDLE.
- Reset mid-frame: lines return to 1 immediately. A partial frame is never resumed.

Optional Feature:
- Macro: `PS2_TYPEMATIC_EN`.
- When defined, the block tracks the last pressed {ext, code}:
  - Once the key has been held 500 ms (CLK_HZ/2 cycles), its make bytes are re-enqueued every 92 ms (CLK_HZ×92/1000), subject to the same atomic admission.
  - Any release or new press restarts tracking. Only a release of the tracked key stops repeats.
- When undefined: no repeat logic, one byte sequence per event only.

Decomposition:
- Package `pc8001m_ps2_pkg` contains:
  - state enum `ser_state_t`;
  - constants PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0, PS2_FRAME_CELLS=11;
  - function `odd_parity(byte)`.
- Sub-module `ps2_byte_fifo`: parameterized FIFO_DEPTH, 8-bit data, push/pop/count outputs.

Test Plan:
- Reset release with ps2_key[10]=1 → no frame emitted and busy stays 0 for 100k cycles.
- Toggle with {press=1, ext=0, code=8'h1C} → one frame on the lines: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1; each clk-low phase is 1145 cycles.
- Toggle with {press=0, ext=1, code=8'h75} → three frames E0, F0, 75 in order, each followed by an idle gap of 4580 cycles or more.
- Fill the FIFO to 14 bytes, then apply a release+ext event (N=3) → overflow pulses once, FIFO count stays 14, and a subsequent 1-byte event is accepted.
- Assert reset_n=0 at DATA bit 4 → both lines go to 1 in the same cycle; after release, no residual frame and FIFO empty.
- With `PS2_TYPEMATIC_EN`, hold code 8'h1C → first repeat enqueued at 14318180 cycles, then every 2634545 cycles; release → F0,1C sent and no further repeats.
